// File: rtl/ipv4_checksum_stream_check.sv
// Streaming IPv4 header checksum checker. Monitors an Ethernet AXI-Stream and queues
// one 2-bit status record per packet, with saturating per-class statistics.
module ipv4_checksum_stream_check #(
   parameter int unsigned DATA_BYTES     = 8,
   parameter bit          VLAN_EN        = 1'b1,
   parameter int unsigned RES_FIFO_DEPTH = 4,
   parameter int unsigned COUNT_WIDTH    = 32
) (
   input  logic                    clk,
   input  logic                    sreset,
   input  logic [DATA_BYTES*8-1:0] s_axis_tdata,
   input  logic [DATA_BYTES-1:0]   s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [1:0]              res_status,
   output logic [COUNT_WIDTH-1:0]  cnt_good,
   output logic [COUNT_WIDTH-1:0]  cnt_bad,
   output logic [COUNT_WIDTH-1:0]  cnt_other,
   output logic [COUNT_WIDTH-1:0]  cnt_drop,
   input  logic                    cnt_clear
);

   localparam int unsigned PtrW = $clog2(RES_FIFO_DEPTH);

   typedef enum logic [1:0] {StEth, StHdr, StSkip} state_e;

   state_e      state_q, state_d;
   logic [15:0] off_q, off_d;
   logic [23:0] acc_q, acc_d;
   logic [7:0]  b12_q, b13_q, b14_q, b16_q, b17_q, b18_q;
   logic [7:0]  b12_c, b13_c, b14_c, b16_c, b17_c, b18_c;

   logic        beat, vlan_c, is_ip, ihl_ok, seen_ver, hdr_done;
   logic [16:0] lane_off, nkeep, end_off, ip_start, hdr_end;
   logic [15:0] etype;
   logic [7:0]  ver_ihl;
   logic [23:0] beat_sum;

   logic        pend_valid_q, pend_valid_d, pend_chk_q, pend_chk_d;
   logic [1:0]  pend_status_q, pend_status_d;
   logic [23:0] pend_acc_q, pend_acc_d;

   logic [16:0] fold1;
   logic [15:0] fold2;
   logic [1:0]  res_new;

   logic [1:0]  mem_q [RES_FIFO_DEPTH];
   logic [PtrW:0] wr_q, rd_q;
   logic        full, empty, pop, push, drop;

   // Per-beat parse: forward header bytes seen in this beat and sum kept header words.
   always_comb begin
      beat     = s_axis_tvalid && s_axis_tready;
      b12_c    = b12_q;
      b13_c    = b13_q;
      b14_c    = b14_q;
      b16_c    = b16_q;
      b17_c    = b17_q;
      b18_c    = b18_q;
      nkeep    = '0;
      lane_off = '0;
      for (int k = 0; k < DATA_BYTES; k++) begin
         lane_off = {1'b0, off_q} + 17'(k);
         if (s_axis_tkeep[k]) begin
            nkeep = nkeep + 17'd1;
            if (lane_off == 17'd12) b12_c = s_axis_tdata[8*k +: 8];
            if (lane_off == 17'd13) b13_c = s_axis_tdata[8*k +: 8];
            if (lane_off == 17'd14) b14_c = s_axis_tdata[8*k +: 8];
            if (lane_off == 17'd16) b16_c = s_axis_tdata[8*k +: 8];
            if (lane_off == 17'd17) b17_c = s_axis_tdata[8*k +: 8];
            if (lane_off == 17'd18) b18_c = s_axis_tdata[8*k +: 8];
         end
      end
      vlan_c   = VLAN_EN && ({b12_c, b13_c} == 16'h8100);
      ip_start = vlan_c ? 17'd18 : 17'd14;
      etype    = vlan_c ? {b16_c, b17_c} : {b12_c, b13_c};
      ver_ihl  = vlan_c ? b18_c : b14_c;
      hdr_end  = ip_start + {11'd0, ver_ihl[3:0], 2'b00};
      // Words start at even offsets; only words lying wholly inside the header count.
      beat_sum = '0;
      for (int k = 0; k < DATA_BYTES; k += 2) begin
         lane_off = {1'b0, off_q} + 17'(k);
         if (s_axis_tkeep[k+1] && (state_q != StSkip) && (lane_off >= ip_start) &&
             (lane_off < hdr_end)) begin
            beat_sum = beat_sum + {8'd0, s_axis_tdata[8*k +: 8], s_axis_tdata[8*(k+1) +: 8]};
         end
      end
      end_off  = {1'b0, off_q} + nkeep;
      is_ip    = (etype == 16'h0800) && (ver_ihl[7:4] == 4'd4);
      ihl_ok   = ver_ihl[3:0] >= 4'd5;
      seen_ver = (state_q != StEth) || (end_off > ip_start);
      hdr_done = (state_q == StSkip) || (end_off >= hdr_end);
   end

   // Next-state for the packet walker and the pending result handed to the fold stage.
   always_comb begin
      state_d       = state_q;
      off_d         = off_q;
      acc_d         = acc_q;
      pend_valid_d  = 1'b0;
      pend_chk_d    = 1'b0;
      pend_status_d = 2'b10;
      pend_acc_d    = acc_q + beat_sum;
      if (beat) begin
         if (s_axis_tlast) begin
            state_d      = StEth;
            off_d        = '0;
            acc_d        = '0;
            pend_valid_d = 1'b1;
            if (!seen_ver || !is_ip) pend_status_d = 2'b10;
            else if (!ihl_ok)        pend_status_d = 2'b11;
            else if (!hdr_done)      pend_status_d = 2'b10;
            else                     pend_chk_d    = 1'b1;
         end else begin
            // Offset saturates; only the payload can be that long and it is never summed.
            off_d = end_off[16] ? 16'hFFFF : end_off[15:0];
            acc_d = acc_q + beat_sum;
            unique case (state_q)
               StEth: begin
                  if (seen_ver) state_d = (!is_ip || !ihl_ok || hdr_done) ? StSkip : StHdr;
               end
               StHdr:   if (hdr_done) state_d = StSkip;
               StSkip:  state_d = StSkip;
               default: state_d = StEth;
            endcase
         end
      end
   end

   // Walker state, accumulator and captured L2/L3 bytes.
   always_ff @(posedge clk) begin
      if (sreset) begin
         state_q       <= StEth;
         off_q         <= '0;
         acc_q         <= '0;
         b12_q         <= '0;
         b13_q         <= '0;
         b14_q         <= '0;
         b16_q         <= '0;
         b17_q         <= '0;
         b18_q         <= '0;
         pend_valid_q  <= 1'b0;
         pend_chk_q    <= 1'b0;
         pend_status_q <= 2'b00;
         pend_acc_q    <= '0;
      end else begin
         state_q       <= state_d;
         off_q         <= off_d;
         acc_q         <= acc_d;
         pend_valid_q  <= pend_valid_d;
         pend_chk_q    <= pend_chk_d;
         pend_status_q <= pend_status_d;
         pend_acc_q    <= pend_acc_d;
         if (beat) begin
            b12_q <= b12_c;
            b13_q <= b13_c;
            b14_q <= b14_c;
            b16_q <= b16_c;
            b17_q <= b17_c;
            b18_q <= b18_c;
         end
      end
   end

   // Ones-complement fold of the finished sum and FIFO push/pop decode.
   always_comb begin
      fold1   = {1'b0, pend_acc_q[15:0]} + {9'd0, pend_acc_q[23:16]};
      fold2   = fold1[15:0] + {15'd0, fold1[16]};
      res_new = pend_chk_q ? ((fold2 == 16'hFFFF) ? 2'b00 : 2'b01) : pend_status_q;
      empty   = (wr_q == rd_q);
      full    = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
      pop     = !empty && res_ready;
      push    = pend_valid_q && (!full || pop);
      drop    = pend_valid_q && full && !pop;
      res_valid  = !empty;
      res_status = mem_q[rd_q[PtrW-1:0]];
   end

   // Result FIFO storage and pointers.
   always_ff @(posedge clk) begin
      if (sreset) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < RES_FIFO_DEPTH; i++) mem_q[i] <= 2'b00;
      end else begin
         if (push) begin
            mem_q[wr_q[PtrW-1:0]] <= res_new;
            wr_q <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
      end
   end

   // Saturating statistics; a clear overrides any same-cycle increment.
   always_ff @(posedge clk) begin
      if (sreset || cnt_clear) begin
         cnt_good  <= '0;
         cnt_bad   <= '0;
         cnt_other <= '0;
         cnt_drop  <= '0;
      end else begin
         if (push && (res_new == 2'b00) && (cnt_good != '1))  cnt_good  <= cnt_good + COUNT_WIDTH'(1);
         if (push && (res_new == 2'b01) && (cnt_bad != '1))   cnt_bad   <= cnt_bad + COUNT_WIDTH'(1);
         if (push && res_new[1] && (cnt_other != '1))         cnt_other <= cnt_other + COUNT_WIDTH'(1);
         if (drop && (cnt_drop != '1))                        cnt_drop  <= cnt_drop + COUNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_ipv4_checksum_stream_check.sv
// Scoreboard bench for ipv4_checksum_stream_check: directed frames plus random good/bad traffic.
module tb_ipv4_checksum_stream_check;

   localparam int unsigned DB = 8;

   logic          clk = 1'b0;
   logic          sreset;
   logic [DB*8-1:0] s_axis_tdata;
   logic [DB-1:0] s_axis_tkeep;
   logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic          res_valid, res_ready, cnt_clear;
   logic [1:0]    res_status;
   logic [31:0]   cnt_good, cnt_bad, cnt_other, cnt_drop;

   ipv4_checksum_stream_check #(
      .DATA_BYTES(DB), .VLAN_EN(1'b1), .RES_FIFO_DEPTH(4), .COUNT_WIDTH(32)
   ) dut (
      .clk(clk), .sreset(sreset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_axis_tlast),
      .res_valid(res_valid), .res_ready(res_ready), .res_status(res_status),
      .cnt_good(cnt_good), .cnt_bad(cnt_bad), .cnt_other(cnt_other), .cnt_drop(cnt_drop),
      .cnt_clear(cnt_clear)
   );

   always #5 clk = ~clk;

   localparam logic [159:0] HdrGood = 160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7;
   localparam logic [159:0] HdrBad  = 160'h4500_0073_0000_4000_4011_B862_C0A8_0001_C0A8_00C7;
   localparam logic [159:0] HdrIhl6 = 160'h4600_0073_0000_4000_4011_B55F_C0A8_0001_C0A8_00C7;
   localparam logic [159:0] HdrIhl3 = 160'h4300_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7;

   int          checks = 0, failures = 0;
   int          m_good = 0, m_bad = 0, m_other = 0, m_drop = 0;
   logic [1:0]  exp_q[$];
   logic [7:0]  frame[$];
   bit          stall_en = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic push_exp(input logic [1:0] st, input bit kept);
      if (kept) begin
         exp_q.push_back(st);
         if (st == 2'b00)      m_good++;
         else if (st == 2'b01) m_bad++;
         else                  m_other++;
      end else begin
         m_drop++;
      end
   endtask

   task automatic add_eth(input bit vlan, input logic [15:0] et);
      for (int i = 0; i < 12; i++) frame.push_back(8'(8'h10 + i));
      if (vlan) begin
         frame.push_back(8'h81); frame.push_back(8'h00);
         frame.push_back(8'h00); frame.push_back(8'h05);
      end
      frame.push_back(et[15:8]);
      frame.push_back(et[7:0]);
   endtask

   task automatic add_hdr20(input logic [159:0] v);
      for (int i = 0; i < 20; i++) frame.push_back(v[159-8*i -: 8]);
   endtask

   task automatic add_pad(input int n);
      for (int i = 0; i < n; i++) frame.push_back(8'(8'hA0 + i));
   endtask

   // Random IPv4 frame with a correctly computed checksum, optionally corrupted by one bit.
   task automatic add_rand_pkt(output logic [1:0] st);
      logic [7:0]  h[$];
      logic [31:0] s;
      logic [15:0] cs;
      int ihl = $urandom_range(5, 6);
      bit vlan = 1'($urandom);
      bit bad = 1'($urandom);
      for (int i = 0; i < 4*ihl; i++) h.push_back(8'($urandom));
      h[0] = {4'h4, 4'(ihl)};
      h[10] = 8'h00;
      h[11] = 8'h00;
      s = 0;
      for (int i = 0; i < 4*ihl; i += 2) s = s + {16'd0, h[i], h[i+1]};
      s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      cs = ~s[15:0];
      h[10] = cs[15:8];
      h[11] = cs[7:0] ^ {7'd0, bad};
      add_eth(vlan, 16'h0800);
      foreach (h[i]) frame.push_back(h[i]);
      add_pad($urandom_range(0, 17));
      st = bad ? 2'b01 : 2'b00;
   endtask

   // Drive the built frame; with_last=0 stops after nbeats beats without tlast.
   task automatic drive_frame(input bit with_last, input int nbeats);
      int n = frame.size();
      int i = 0;
      int b = 0;
      while (i < n && (with_last || b < nbeats)) begin
         s_axis_tdata = '0;
         s_axis_tkeep = '0;
         for (int k = 0; k < DB; k++) begin
            if (i + k < n) begin
               s_axis_tdata[8*k +: 8] = frame[i+k];
               s_axis_tkeep[k] = 1'b1;
            end
         end
         s_axis_tlast  = with_last && (i + DB >= n);
         s_axis_tvalid = 1'b1;
         do begin
            s_axis_tready = !(stall_en && ($urandom_range(0, 7) == 0));
            @(posedge clk); #1;
         end while (!s_axis_tready);
         i += DB;
         b++;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tready = 1'b1;
      frame.delete();
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain got=%0d_pending want=0_pending", name, exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_counters(input string name);
      check({name, "_cnt_good"},  cnt_good,  32'(m_good));
      check({name, "_cnt_bad"},   cnt_bad,   32'(m_bad));
      check({name, "_cnt_other"}, cnt_other, 32'(m_other));
      check({name, "_cnt_drop"},  cnt_drop,  32'(m_drop));
   endtask

   // Monitor: compare every accepted result against the scoreboard in order.
   logic [1:0] mon_want;
   initial begin
      forever begin
         @(negedge clk);
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result got=%0h want=none", res_status);
            end else begin
               mon_want = exp_q.pop_front();
               check("res_status", {30'd0, res_status}, {30'd0, mon_want});
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] st;
      sreset = 1'b1;
      s_axis_tdata = '0; s_axis_tkeep = '0;
      s_axis_tvalid = 1'b0; s_axis_tready = 1'b1; s_axis_tlast = 1'b0;
      res_ready = 1'b1; cnt_clear = 1'b0;
      repeat (3) @(posedge clk);
      #1 sreset = 1'b0;
      @(negedge clk);
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_res_status", {30'd0, res_status}, 32'd0);
      check_counters("rst");

      // Good frame: check exact latency of res_valid.
      push_exp(2'b00, 1'b1);
      add_eth(1'b0, 16'h0800); add_hdr20(HdrGood); add_pad(4);
      drive_frame(1'b1, 0);
      @(negedge clk);
      check("lat_n1_valid", {31'd0, res_valid}, 32'd0);
      @(negedge clk);
      check("lat_n2_valid", {31'd0, res_valid}, 32'd1);
      check("lat_n2_status", {30'd0, res_status}, 32'd0);
      check("lat_n2_cnt_good", cnt_good, 32'd1);
      drain("good");

      push_exp(2'b01, 1'b1);
      add_eth(1'b0, 16'h0800); add_hdr20(HdrBad); add_pad(4);
      drive_frame(1'b1, 0);
      drain("bad");
      check("bad_cnt_bad", cnt_bad, 32'd1);

      push_exp(2'b00, 1'b1);
      add_eth(1'b1, 16'h0800); add_hdr20(HdrGood); add_pad(2);
      drive_frame(1'b1, 0);

      push_exp(2'b00, 1'b1);
      add_eth(1'b0, 16'h0800); add_hdr20(HdrIhl6); add_pad(-0);
      for (int i = 0; i < 4; i++) frame.push_back(8'h01);
      add_pad(6);
      drive_frame(1'b1, 0);

      // IHL=6 header cut after 20 IP bytes.
      push_exp(2'b10, 1'b1);
      add_eth(1'b0, 16'h0800); add_hdr20(HdrIhl6);
      drive_frame(1'b1, 0);
      drain("directed");
      check_counters("directed");

      // Random back-to-back traffic with occasional tready stalls.
      stall_en = 1'b1;
      for (int p = 0; p < 100; p++) begin
         add_rand_pkt(st);
         push_exp(st, 1'b1);
         drive_frame(1'b1, 0);
      end
      stall_en = 1'b0;
      drain("random");
      check_counters("random");

      // FIFO overflow: six records, four retained.
      res_ready = 1'b0;
      push_exp(2'b00, 1'b1); add_eth(1'b0, 16'h0800); add_hdr20(HdrGood); drive_frame(1'b1, 0);
      push_exp(2'b01, 1'b1); add_eth(1'b0, 16'h0800); add_hdr20(HdrBad);  drive_frame(1'b1, 0);
      push_exp(2'b00, 1'b1); add_eth(1'b1, 16'h0800); add_hdr20(HdrGood); drive_frame(1'b1, 0);
      push_exp(2'b10, 1'b1); add_eth(1'b0, 16'h86DD); add_hdr20(HdrGood); drive_frame(1'b1, 0);
      push_exp(2'b00, 1'b0); add_eth(1'b0, 16'h0800); add_hdr20(HdrGood); drive_frame(1'b1, 0);
      push_exp(2'b01, 1'b0); add_eth(1'b0, 16'h0800); add_hdr20(HdrBad);  drive_frame(1'b1, 0);
      repeat (4) @(posedge clk);
      #1;
      check("full_res_valid", {31'd0, res_valid}, 32'd1);
      check("full_cnt_drop", cnt_drop, 32'(m_drop));
      check("full_cnt_drop_abs", cnt_drop, 32'd2);
      res_ready = 1'b1;
      drain("overflow");
      check_counters("overflow");

      // Clear coincident with a good push.
      push_exp(2'b00, 1'b1);
      add_eth(1'b0, 16'h0800); add_hdr20(HdrGood);
      drive_frame(1'b1, 0);
      cnt_clear = 1'b1;
      @(posedge clk); #1;
      cnt_clear = 1'b0;
      m_good = 0; m_bad = 0; m_other = 0; m_drop = 0;
      drain("clear");
      check_counters("clear");

      push_exp(2'b10, 1'b1);
      add_eth(1'b0, 16'h86DD); add_hdr20(HdrGood); add_pad(3);
      drive_frame(1'b1, 0);
      push_exp(2'b11, 1'b1);
      add_eth(1'b0, 16'h0800); add_hdr20(HdrIhl3); add_pad(3);
      drive_frame(1'b1, 0);
      drain("other");
      check("other_cnt_other", cnt_other, 32'd2);

      // Reset in the middle of a header, then a clean frame.
      add_eth(1'b0, 16'h0800); add_hdr20(HdrGood);
      drive_frame(1'b0, 3);
      sreset = 1'b1;
      @(posedge clk); #1;
      sreset = 1'b0;
      m_good = 0; m_bad = 0; m_other = 0; m_drop = 0;
      check("srst_cnt_other", cnt_other, 32'd0);
      push_exp(2'b00, 1'b1);
      add_eth(1'b0, 16'h0800); add_hdr20(HdrGood); add_pad(5);
      drive_frame(1'b1, 0);
      drain("post_srst");
      check_counters("post_srst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ipv4_checksum_stream_check.md
# ipv4_checksum_stream_check

Streaming IPv4 header checksum checker that monitors an Ethernet AXI-Stream on the packet datapath and issues one status record per packet. It generalises the single-cycle header verifier. It is parametrised in bus width, handles optional 802.1Q tags and IPv4 options (IHL 5..15), and accumulates the sum across beats. Results are buffered in a small FIFO with a valid/ready handshake, and per-class counters are exposed to the register block.

## Interface
- DATA_BYTES, 8: stream width in bytes; even, 4..64.
- VLAN_EN, 1: 1 = parse a single 0x8100 tag; 0 = treat 0x8100 as non-IPv4.
- RES_FIFO_DEPTH, 4: result FIFO depth; power of 2, ≥2.
- COUNT_WIDTH, 32: width of each statistics counter.
- clk  in  1  single clock domain.
- sreset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_BYTES*8  monitored data; packet byte k of a beat sits in tdata[8k+7:8k] (first network byte in lane 0).
- s_axis_tkeep  in  DATA_BYTES  byte enables; contiguous from lane 0.
- s_axis_tvalid, s_axis_tready, s_axis_tlast  in  1 each  monitored handshake (block never drives tready).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_status  out  2  00 checksum good, 01 checksum bad, 10 not IPv4 / truncated, 11 IHL<5.
- cnt_good, cnt_bad, cnt_other, cnt_drop  out  COUNT_WIDTH each  saturating statistics.
- cnt_clear  in  1  synchronous clear of all four counters.

## Operation
- Beat = cycle with tvalid&&tready. Byte offset counter tracks packet position; resets to 0 after a tlast beat.
- IP start: offset 14. If VLAN_EN and bytes 12..13 = 0x8100, ethertype is at bytes 16..17 and IP start is 18.
- IPv4 requires ethertype 0x0800 and version nibble 4. Header length = 4*IHL bytes from IP start.
- Words = {byte at even offset, next byte}. The IP start is always even, so words never straddle beats.
- Per beat, all header words with both bytes kept are summed (adder tree) into a 24-bit accumulator. The checksum field is included.
- FSM:
  - ETH: parse L2, up to IP start plus 1.
  - HDR: accumulate until 4*IHL bytes are consumed.
  - SKIP: ignore the payload until tlast.
  - Every tlast beat returns the FSM to ETH and triggers result generation.
- Fold: sum = acc[15:0] + acc[23:16], then end-around carry once more. Good iff the folded value = 0xFFFF.
- Status priority:
  - Non-IPv4 ethertype/version → 10.
  - IHL<5 → 11; accumulation stops.
  - tlast before the full header → 10.
  - Otherwise 00 or 01.
- FIFO:
  - Push on the cycle after the tlast beat.
  - Full and not popping in that cycle → record dropped and cnt_drop increments.
  - Push and pop in the same cycle while full is legal and is not a drop.
- Counters increment on push, by class: good = 00, bad = 01, other = 10/11. They saturate at all-ones. cnt_clear in the same cycle as an increment wins (result 0).

## Timing
- Reset values:
  - res_valid=0, res_status=00.
  - All counters 0.
  - FIFO empty, FSM in ETH, accumulator 0.
- Latency: tlast beat in cycle N → record pushed at end of N+1 → res_valid=1 in N+2 if the FIFO was empty. Counters update in N+2.
- res_status is stable while res_valid && !res_ready. A pop occurs on res_valid&&res_ready.
- Back-to-back packets: the first beat of the next packet may occur in cycle N+1. It must parse correctly while the previous result is being folded.
- Single-beat packets (DATA_BYTES ≥ header end) resolve fully in one beat.
- Throughput: one beat per cycle, no bubbles required. The block supports at most one packet end per cycle.
- sreset mid-packet discards partial state. The next beat after reset is offset 0.

## Test plan
- DATA_BYTES=8. IPv4 header 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7 after ethertype 0800 → res_status=00 in N+2, cnt_good=1.
- Same frame with checksum B862 → status 01, cnt_bad=1. Same frame with 8100 tag inserted (VLAN_EN=1) → 00.
- IHL=6 header with 4 option bytes 01 01 01 01 and the checksum recomputed accordingly → 00. The same frame cut by tlast at IP byte 20 → 10.
- 100 random back-to-back packets, mixed good/bad, res_ready=1 → statuses match the model in order, and counters equal the model totals.
- res_ready=0 with RES_FIFO_DEPTH+2 packets → first 4 retained in order, cnt_drop=2. Then assert cnt_clear together with a good push → all counters 0.
- Ethertype 86DD, and separately IHL=3 → statuses 10 and 11, cnt_other=2. sreset mid-header, then a good frame → 00.
